pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard / divide controller.
package pipe_ctrl_pkg;

    // Divide tracking FSM states.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StWb   = 2'd2
    } div_state_e;

    localparam logic        WriteEnable       = 1'b1;
    localparam logic        WriteDisable      = 1'b0;
    localparam logic [4:0]  ZeroReg           = 5'd0;
    localparam logic [31:0] ZeroWord          = 32'd0;
    localparam int unsigned DivTimeoutDefault = 64;

    // Wait counter width: enough for the timeout value, never below 6 bits.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout);
        return (w < 6) ? 6 : w;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline control: multi-cycle divide tracking, write-back port arbitration,
// RAW stall against the pending divide destination, and jump/flush gating.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = DivTimeoutDefault
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_start_i,
    input  logic [4:0]  ex_div_rd_i,
    input  logic        ex_we_i,
    input  logic [4:0]  ex_waddr_i,
    input  logic [31:0] ex_wdata_i,
    input  logic        ex_jump_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic [4:0]  id_raddr1_i,
    input  logic [4:0]  id_raddr2_i,
    input  logic        div_done_i,
    input  logic [31:0] div_result_i,
    output logic        div_start_o,
    output logic        stall_o,
    output logic        flush_o,
    output logic        jump_o,
    output logic [31:0] jump_addr_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        div_busy_o,
    output logic        div_timeout_o
);

    localparam int unsigned     CntW    = cnt_width(DIV_TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(DIV_TIMEOUT - 1);

    div_state_e      r_state, w_state_next;
    logic [CntW-1:0] r_cnt, w_cnt_next;
    logic [4:0]      r_div_rd, w_div_rd_next;
    logic [31:0]     r_div_result, w_div_result_next;
    logic            r_timeout, w_timeout_next;

    logic w_busy;
    logic w_raw;
    logic w_stall;

    // State register; reset drops any in-flight divide immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_div_rd     <= ZeroReg;
            r_div_result <= ZeroWord;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_div_rd     <= w_div_rd_next;
            r_div_result <= w_div_result_next;
            r_timeout    <= w_timeout_next;
        end
    end

    // Next-state: start in IDLE, count/complete/time out in BUSY, one WB cycle.
    always_comb begin
        w_state_next      = r_state;
        w_cnt_next        = r_cnt;
        w_div_rd_next     = r_div_rd;
        w_div_result_next = r_div_result;
        w_timeout_next    = 1'b0;
        case (r_state)
            StIdle: begin
                if (ex_div_start_i) begin
                    w_state_next  = StBusy;
                    w_div_rd_next = ex_div_rd_i;
                    w_cnt_next    = '0;
                end
            end
            StBusy: begin
                w_cnt_next = r_cnt + 1'b1;
                // A done arriving on the last allowed cycle still completes.
                if (div_done_i) begin
                    w_div_result_next = div_result_i;
                    w_state_next      = StWb;
                end else if (r_cnt == CntLast) begin
                    w_state_next   = StIdle;
                    w_timeout_next = 1'b1;
                end
            end
            StWb: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Hazard detection; built only from state and EX/ID inputs, never from jump/flush.
    always_comb begin
        w_busy  = (r_state != StIdle);
        w_raw   = w_busy && (r_div_rd != ZeroReg) &&
                  ((id_raddr1_i == r_div_rd) || (id_raddr2_i == r_div_rd));
        w_stall = ((r_state == StWb) && ex_we_i) || (w_busy && ex_div_start_i) || w_raw;
    end

    // Outputs; everything forced low while reset is held.
    always_comb begin
        div_start_o   = 1'b0;
        stall_o       = 1'b0;
        flush_o       = 1'b0;
        jump_o        = 1'b0;
        jump_addr_o   = ZeroWord;
        reg_we_o      = WriteDisable;
        reg_waddr_o   = ZeroReg;
        reg_wdata_o   = ZeroWord;
        div_busy_o    = 1'b0;
        div_timeout_o = 1'b0;
        if (!rst) begin
            div_start_o   = (r_state == StIdle) && ex_div_start_i;
            stall_o       = w_stall;
            // A stalled jump stays in EX and is presented again next cycle.
            jump_o        = ex_jump_i && !w_stall;
            flush_o       = ex_jump_i && !w_stall;
            jump_addr_o   = ex_jump_addr_i;
            div_busy_o    = w_busy;
            div_timeout_o = r_timeout;
            if (r_state == StWb) begin
                // Divide owns the write port; a colliding EX write is held by the stall.
                reg_we_o    = (r_div_rd != ZeroReg) ? WriteEnable : WriteDisable;
                reg_waddr_o = r_div_rd;
                reg_wdata_o = r_div_result;
            end else begin
                reg_we_o    = (ex_we_i && !w_stall) ? WriteEnable : WriteDisable;
                reg_waddr_o = ex_waddr_i;
                reg_wdata_o = ex_wdata_i;
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the divide lifecycle.
module tb_pipe_ctrl;

    localparam int unsigned Timeout = 64;

    logic        clk;
    logic        rst;
    logic        ex_div_start_i;
    logic [4:0]  ex_div_rd_i;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        ex_jump_i;
    logic [31:0] ex_jump_addr_i;
    logic [4:0]  id_raddr1_i;
    logic [4:0]  id_raddr2_i;
    logic        div_done_i;
    logic [31:0] div_result_i;
    logic        div_start_o;
    logic        stall_o;
    logic        flush_o;
    logic        jump_o;
    logic [31:0] jump_addr_o;
    logic        reg_we_o;
    logic [4:0]  reg_waddr_o;
    logic [31:0] reg_wdata_o;
    logic        div_busy_o;
    logic        div_timeout_o;

    int n_cmp = 0;
    int n_err = 0;

    // Model: a divide is either waiting (with its age), or its result is due this cycle.
    bit          m_waiting;
    int          m_age;
    bit          m_result_due;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    bit          m_timeout;

    pipe_ctrl #(.DIV_TIMEOUT(Timeout)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_div_start_i (ex_div_start_i),
        .ex_div_rd_i    (ex_div_rd_i),
        .ex_we_i        (ex_we_i),
        .ex_waddr_i     (ex_waddr_i),
        .ex_wdata_i     (ex_wdata_i),
        .ex_jump_i      (ex_jump_i),
        .ex_jump_addr_i (ex_jump_addr_i),
        .id_raddr1_i    (id_raddr1_i),
        .id_raddr2_i    (id_raddr2_i),
        .div_done_i     (div_done_i),
        .div_result_i   (div_result_i),
        .div_start_o    (div_start_o),
        .stall_o        (stall_o),
        .flush_o        (flush_o),
        .jump_o         (jump_o),
        .jump_addr_o    (jump_addr_o),
        .reg_we_o       (reg_we_o),
        .reg_waddr_o    (reg_waddr_o),
        .reg_wdata_o    (reg_wdata_o),
        .div_busy_o     (div_busy_o),
        .div_timeout_o  (div_timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        ex_div_start_i = 1'b0;
        ex_div_rd_i    = '0;
        ex_we_i        = 1'b0;
        ex_waddr_i     = '0;
        ex_wdata_i     = '0;
        ex_jump_i      = 1'b0;
        ex_jump_addr_i = '0;
        id_raddr1_i    = '0;
        id_raddr2_i    = '0;
        div_done_i     = 1'b0;
        div_result_i   = '0;
    endtask

    task automatic model_reset();
        m_waiting    = 1'b0;
        m_age        = 0;
        m_result_due = 1'b0;
        m_rd         = '0;
        m_res        = '0;
        m_timeout    = 1'b0;
    endtask

    // Let inputs settle, then compare all outputs with the model's expectation.
    task automatic eval();
        bit          e_busy, e_stall, e_start, e_jump, e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata, e_jaddr;
        #1;
        if (rst) begin
            e_busy = 0; e_stall = 0; e_start = 0; e_jump = 0; e_we = 0;
            e_waddr = '0; e_wdata = '0; e_jaddr = '0;
        end else begin
            e_busy  = m_waiting || m_result_due;
            e_stall = (m_result_due && ex_we_i) || (e_busy && ex_div_start_i) ||
                      (e_busy && m_rd != 0 && (id_raddr1_i == m_rd || id_raddr2_i == m_rd));
            e_start = !e_busy && ex_div_start_i;
            e_jump  = ex_jump_i && !e_stall;
            e_jaddr = ex_jump_addr_i;
            if (m_result_due) begin
                e_we = (m_rd != 0); e_waddr = m_rd; e_wdata = m_res;
            end else begin
                e_we = ex_we_i && !e_stall; e_waddr = ex_waddr_i; e_wdata = ex_wdata_i;
            end
        end
        check_val("ctrl", {25'd0, div_start_o, stall_o, flush_o, jump_o, reg_we_o, div_busy_o,
                           div_timeout_o},
                  {25'd0, e_start, e_stall, e_jump, e_jump, e_we, e_busy, (!rst && m_timeout)});
        check_val("jaddr", jump_addr_o, e_jaddr);
        if (e_we || rst) begin
            check_val("waddr", 32'(reg_waddr_o), 32'(e_waddr));
            check_val("wdata", reg_wdata_o, e_wdata);
        end
    endtask

    // Advance the model by one clock with the current inputs, then move to the next negedge.
    task automatic adv();
        if (rst) begin
            model_reset();
        end else begin
            m_timeout = 1'b0;
            if (m_result_due) begin
                m_result_due = 1'b0;
            end else if (m_waiting) begin
                m_age++;
                if (div_done_i) begin
                    m_res        = div_result_i;
                    m_result_due = 1'b1;
                    m_waiting    = 1'b0;
                end else if (m_age == Timeout) begin
                    m_waiting = 1'b0;
                    m_timeout = 1'b1;
                end
            end else if (ex_div_start_i) begin
                m_waiting = 1'b1;
                m_age     = 0;
                m_rd      = ex_div_rd_i;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        eval();
        check_val("rst_busy", 32'(div_busy_o), 32'd0);
        adv();
        rst = 1'b0;

        // Divide to x5, result 7 after 33 cycles.
        ex_div_start_i = 1'b1; ex_div_rd_i = 5'd5;
        eval();
        check_val("div_start", 32'(div_start_o), 32'd1);
        adv();
        clear_inputs();
        repeat (32) begin eval(); adv(); end
        div_done_i = 1'b1; div_result_i = 32'h7;
        eval(); adv();
        clear_inputs();
        eval();
        check_val("wb_we", 32'(reg_we_o), 32'd1);
        check_val("wb_waddr", 32'(reg_waddr_o), 32'd5);
        check_val("wb_wdata", reg_wdata_o, 32'h7);
        adv();
        eval();
        check_val("busy_low", 32'(div_busy_o), 32'd0);
        adv();

        // RAW on x5 through BUSY and WB.
        ex_div_start_i = 1'b1; ex_div_rd_i = 5'd5;
        eval(); adv();
        clear_inputs(); id_raddr2_i = 5'd5;
        repeat (3) begin eval(); check_val("raw_busy", 32'(stall_o), 32'd1); adv(); end
        div_done_i = 1'b1; div_result_i = 32'h55;
        eval(); adv();
        clear_inputs(); id_raddr2_i = 5'd5;
        eval(); check_val("raw_wb", 32'(stall_o), 32'd1); adv();
        eval(); check_val("raw_idle", 32'(stall_o), 32'd0); adv();

        // Divide to x0: no RAW stall on source x0, no write-back.
        clear_inputs(); ex_div_start_i = 1'b1; ex_div_rd_i = 5'd0;
        eval(); adv();
        clear_inputs();
        eval(); check_val("x0_nostall", 32'(stall_o), 32'd0);
        div_done_i = 1'b1; div_result_i = 32'h99;
        adv();
        clear_inputs();
        eval(); check_val("x0_nowb", 32'(reg_we_o), 32'd0); adv();

        // Write-back collision with a pending EX write and jump.
        ex_div_start_i = 1'b1; ex_div_rd_i = 5'd9;
        eval(); adv();
        clear_inputs();
        repeat (2) begin eval(); adv(); end
        div_done_i = 1'b1; div_result_i = 32'h1234;
        eval(); adv();
        clear_inputs();
        ex_we_i = 1'b1; ex_waddr_i = 5'd3; ex_wdata_i = 32'hAA;
        ex_jump_i = 1'b1; ex_jump_addr_i = 32'h200;
        eval();
        check_val("col_stall", 32'(stall_o), 32'd1);
        check_val("col_waddr", 32'(reg_waddr_o), 32'd9);
        check_val("col_wdata", reg_wdata_o, 32'h1234);
        check_val("col_jump", 32'(jump_o), 32'd0);
        adv();
        eval();
        check_val("held_stall", 32'(stall_o), 32'd0);
        check_val("held_waddr", 32'(reg_waddr_o), 32'd3);
        check_val("held_wdata", reg_wdata_o, 32'hAA);
        check_val("held_jump", 32'({jump_o, flush_o}), 32'd3);
        adv();
        clear_inputs(); ex_jump_i = 1'b1; ex_jump_addr_i = 32'h100;
        eval();
        check_val("idle_jump", 32'({jump_o, flush_o}), 32'd3);
        check_val("idle_jaddr", jump_addr_o, 32'h100);
        adv();

        // Timeout: 64 waiting cycles, one pulse, no write.
        clear_inputs(); ex_div_start_i = 1'b1; ex_div_rd_i = 5'd4;
        eval(); adv();
        clear_inputs();
        repeat (Timeout) begin eval(); adv(); end
        eval();
        check_val("to_pulse", 32'(div_timeout_o), 32'd1);
        check_val("to_idle", 32'(div_busy_o), 32'd0);
        check_val("to_nowe", 32'(reg_we_o), 32'd0);
        adv();
        eval(); check_val("to_once", 32'(div_timeout_o), 32'd0); adv();

        // Asynchronous reset mid-divide, between clock edges.
        ex_div_start_i = 1'b1; ex_div_rd_i = 5'd6;
        eval(); adv();
        clear_inputs();
        repeat (5) begin eval(); adv(); end
        rst = 1'b1; #1; rst = 1'b0; #1;
        check_val("async_rst", 32'(div_busy_o), 32'd0);
        model_reset();
        eval(); adv();

        // Reset held mid-divide while done arrives, then late done in IDLE.
        ex_div_start_i = 1'b1; ex_div_rd_i = 5'd6;
        eval(); adv();
        clear_inputs();
        repeat (3) begin eval(); adv(); end
        rst = 1'b1; div_done_i = 1'b1; div_result_i = 32'hDEAD;
        id_raddr1_i = 5'd6; ex_jump_i = 1'b1; ex_jump_addr_i = 32'h40; ex_we_i = 1'b1;
        ex_waddr_i = 5'd2; ex_wdata_i = 32'h11;
        eval(); adv();
        rst = 1'b0; clear_inputs(); div_done_i = 1'b1; div_result_i = 32'hBEEF;
        eval(); adv();
        clear_inputs();
        eval(); check_val("late_done", 32'(reg_we_o), 32'd0); adv();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 299) == 0);
            ex_div_start_i = ($urandom_range(0, 5) == 0);
            ex_div_rd_i    = 5'($urandom_range(0, 3));
            ex_we_i        = 1'($urandom);
            ex_waddr_i     = 5'($urandom);
            ex_wdata_i     = $urandom;
            ex_jump_i      = ($urandom_range(0, 3) == 0);
            ex_jump_addr_i = $urandom;
            id_raddr1_i    = 5'($urandom_range(0, 3));
            id_raddr2_i    = 5'($urandom_range(0, 3));
            div_done_i     = (i < 1500) ? ($urandom_range(0, 15) == 0)
                                        : ($urandom_range(0, 79) == 0);
            div_result_i   = $urandom;
            eval();
            adv();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
